// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I control path:
// opcodes, FSM states, aluOp/aluControl/immSrc/mux-select encodings.
package riscv_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BEQ,
      S_JAL,
      S_TRAP
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from aluOp and instruction funct fields.
// Ports: aluOp, funct3, funct7b5, op5 in; aluControl out.
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [1:0] aluOp,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] aluControl
);

   always_comb begin
      aluControl = ALU_ADD;
      case (aluOp)
         ALUOP_ADD: aluControl = ALU_ADD;
         ALUOP_SUB: aluControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // funct7b5 only means sub for R-type; I-type addi ignores it
               3'b000:  aluControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  aluControl = ALU_SLT;
               3'b110:  aluControl = ALU_OR;
               3'b111:  aluControl = ALU_AND;
               default: aluControl = ALU_ADD;
            endcase
         end
         default: aluControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM main control for the multicycle RV32I datapath.
// In: clk, reset (async high), op, funct3, funct7b5, zero.
// Out: pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA,
//      aluSrcB, aluControl, immSrc, regWrite, illegal.
// MULTICYCLE_CONTROL_TRAP_EN: unknown opcodes enter a sticky TRAP.
module multicycle_control
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pcWrite,
   output logic       adrSrc,
   output logic       memWrite,
   output logic       irWrite,
   output logic [1:0] resultSrc,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [2:0] aluControl,
   output logic [1:0] immSrc,
   output logic       regWrite,
   output logic       illegal
);

   state_t     state;
   state_t     nstate;
   logic [1:0] aluOp;
   logic       pcUpdate;
   logic       branch;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= nstate;
   end

   always_comb begin
      nstate = S_FETCH;
      case (state)
         S_FETCH: nstate = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: nstate = S_MEMADR;
               OP_R:         nstate = S_EXECUTER;
               OP_I:         nstate = S_EXECUTEI;
               OP_BEQ:       nstate = S_BEQ;
               OP_JAL:       nstate = S_JAL;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
               default:      nstate = S_TRAP;
`else
               default:      nstate = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   nstate = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  nstate = S_MEMWB;
         S_EXECUTER: nstate = S_ALUWB;
         S_EXECUTEI: nstate = S_ALUWB;
         S_JAL:      nstate = S_ALUWB;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
         S_TRAP:     nstate = S_TRAP;
`endif
         default:    nstate = S_FETCH;
      endcase
   end

   always_comb begin
      adrSrc    = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      resultSrc = RES_ALUOUT;
      aluSrcA   = SRCA_PC;
      aluSrcB   = SRCB_RD2;
      aluOp     = ALUOP_ADD;
      regWrite  = 1'b0;
      pcUpdate  = 1'b0;
      branch    = 1'b0;
      illegal   = 1'b0;
      case (state)
         S_FETCH: begin
            irWrite   = 1'b1;
            aluSrcB   = SRCB_FOUR;
            resultSrc = RES_ALURESULT;
            pcUpdate  = 1'b1;
         end
         S_DECODE: begin
            aluSrcA = SRCA_OLDPC;
            aluSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            aluSrcA = SRCA_RD1;
            aluSrcB = SRCB_IMM;
         end
         S_MEMREAD: adrSrc = 1'b1;
         S_MEMWB: begin
            resultSrc = RES_DATA;
            regWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            adrSrc   = 1'b1;
            memWrite = 1'b1;
         end
         S_EXECUTER: begin
            aluSrcA = SRCA_RD1;
            aluOp   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            aluSrcA = SRCA_RD1;
            aluSrcB = SRCB_IMM;
            aluOp   = ALUOP_FUNCT;
         end
         S_ALUWB: regWrite = 1'b1;
         S_BEQ: begin
            aluSrcA = SRCA_RD1;
            aluOp   = ALUOP_SUB;
            branch  = 1'b1;
         end
         S_JAL: begin
            aluSrcA  = SRCA_OLDPC;
            aluSrcB  = SRCB_FOUR;
            pcUpdate = 1'b1;
         end
`ifdef MULTICYCLE_CONTROL_TRAP_EN
         S_TRAP: illegal = 1'b1;
`endif
         default: ;
      endcase
   end

   assign pcWrite = pcUpdate | (branch & zero);

   always_comb begin
      case (op)
         OP_SW:   immSrc = IMM_S;
         OP_BEQ:  immSrc = IMM_B;
         OP_JAL:  immSrc = IMM_J;
         default: immSrc = IMM_I;
      endcase
   end

   alu_decoder u_aludec (
      .aluOp      (aluOp),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .op5        (op[5]),
      .aluControl (aluControl)
   );

endmodule
